// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HiLo multiply/divide unit.
//   op_e    : EX-stage operation encoding (MULT, MULTU, DIV, DIVU)
//   state_e : sequencer states
//   WIDTH_DEF : default operand width
//   op_is_signed / op_is_div : decode helpers for op_e
package hilo_muldiv_unit_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the mul/div unit.
//   Start, Op, Kill, OpA, OpB     : issue side (EX drives)
//   Busy, Done, HiLoEn, HiLoWrite : completion side (unit drives)
// master modport = EX stage, slave modport = mul/div unit.
interface hilo_muldiv_unit_if
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic               Start;
  op_e                Op;
  logic               Kill;
  logic [WIDTH-1:0]   OpA;
  logic [WIDTH-1:0]   OpB;
  logic               Busy;
  logic               Done;
  logic               HiLoEn;
  logic [2*WIDTH-1:0] HiLoWrite;

  modport master (
    output Start, Op, Kill, OpA, OpB,
    input  Busy, Done, HiLoEn, HiLoWrite
  );

  modport slave (
    input  Start, Op, Kill, OpA, OpB,
    output Busy, Done, HiLoEn, HiLoWrite
  );

endinterface

// File: rtl/hilo_muldiv_unit_muldiv_datapath.sv
// Arithmetic core of the HiLo mul/div unit.
//   clk    in  : clock
//   load   in  : capture operands (magnitudes, sign flags, op) and seed the step registers
//   step   in  : perform one radix-2 iteration (shift-add multiply or restoring divide)
//   fix    in  : apply sign correction / divide-by-zero override into the result register
//   op     in  : operation being captured on load
//   opa    in  : multiplicand / dividend
//   opb    in  : multiplier / divisor
//   result out : {Hi,Lo} after fix
// Holds data only; sequencing lives in the parent.
module muldiv_datapath
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  op_e                op,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic [2*WIDTH-1:0] result
);

  localparam int W = WIDTH;

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] x, input logic en);
    logic signed [W-1:0] sx;
    sx = x;
    return en ? -sx : sx;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] x, input logic en);
    logic signed [2*W-1:0] sx;
    sx = x;
    return en ? -sx : sx;
  endfunction

  logic [W-1:0]   a_raw;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic           sign_a;
  logic           sign_b;
  logic           is_div;
  logic           b_zero;
  logic [2*W-1:0] prod;
  logic [W-1:0]   rem;
  logic [W-1:0]   quo;
  logic [2*W-1:0] res;

  logic           sa_in;
  logic           sb_in;
  logic [W-1:0]   a_mag_in;
  logic [W-1:0]   b_mag_in;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic           div_ge;
  logic [W-1:0]   div_diff;
  logic [2*W-1:0] fixed;

  always_comb begin
    sa_in    = op_is_signed(op) & opa[W-1];
    sb_in    = op_is_signed(op) & opb[W-1];
    a_mag_in = neg_w(opa, sa_in);
    b_mag_in = neg_w(opb, sb_in);
  end

  // Multiply: low half of prod starts as the multiplier and is consumed from bit 0
  // while the partial product grows into the high half (W+1-bit add keeps the carry).
  // Divide: the partial remainder {rem, next dividend bit} is W+1 bits wide; after a
  // successful subtract it is below the divisor again, so W bits suffice to store it.
  always_comb begin
    mul_sum   = {1'b0, prod[2*W-1:W]} + {1'b0, (prod[0] ? a_mag : {W{1'b0}})};
    div_shift = {rem, quo[W-1]};
    div_ge    = div_shift >= {1'b0, b_mag};
    div_diff  = div_shift[W-1:0] - b_mag;
  end

  // Quotient negates on mixed signs, remainder follows the dividend. Divide by zero
  // bypasses the iteration result entirely.
  always_comb begin
    if (!is_div) begin
      fixed = neg_2w(prod, sign_a ^ sign_b);
    end else if (b_zero) begin
      fixed = {a_raw, {W{1'b1}}};
    end else begin
      fixed = {neg_w(rem, sign_a), neg_w(quo, sign_a ^ sign_b)};
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      a_raw  <= opa;
      a_mag  <= a_mag_in;
      b_mag  <= b_mag_in;
      sign_a <= sa_in;
      sign_b <= sb_in;
      is_div <= op_is_div(op);
      b_zero <= (opb == '0);
      prod   <= {{W{1'b0}}, b_mag_in};
      rem    <= '0;
      quo    <= a_mag_in;
    end else if (step) begin
      if (is_div) begin
        rem <= div_ge ? div_diff : div_shift[W-1:0];
        quo <= {quo[W-2:0], div_ge};
      end else begin
        prod <= {mul_sum, prod[W-1:1]};
      end
    end else if (fix) begin
      res <= fixed;
    end
  end

  assign result = res;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit writing the HiLo register.
//   Clock : system clock, rising edge
//   Reset : asynchronous active-low reset
//   bus   : slave side of hilo_muldiv_unit_if
//           Start/Op/Kill/OpA/OpB in; Busy/Done/HiLoEn/HiLoWrite out
// Sequencer IDLE -> CALC (WIDTH steps) -> FIX -> DONE -> IDLE. The completion
// outputs are registered off the DONE state, so Done/HiLoEn pulse in the cycle
// after DONE, WIDTH+3 cycles after the Start cycle. Busy covers that pulse cycle
// too, which keeps a Start in the pulse cycle from being accepted.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  hilo_muldiv_unit_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state;
  state_e             state_next;
  logic [CNT_W-1:0]   cnt;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] hilo_q;
  logic [2*WIDTH-1:0] dp_result;
  logic               accept;

  assign accept = (state == ST_IDLE) & bus.Start & ~bus.Kill & ~busy_q;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_CALC;
      ST_CALC: if (cnt == '0) state_next = ST_FIX;
      ST_FIX:  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (bus.Kill) state_next = ST_IDLE;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hilo_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt <= CNT_LAST;
      end else if ((state == ST_CALC) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      busy_q <= ~bus.Kill & (accept | (state != ST_IDLE));
      done_q <= ~bus.Kill & (state == ST_DONE);
      if (~bus.Kill && (state == ST_DONE)) begin
        hilo_q <= dp_result;
      end
    end
  end

  muldiv_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk    (Clock),
    .load   (accept),
    .step   (state == ST_CALC),
    .fix    (state == ST_FIX),
    .op     (bus.Op),
    .opa    (bus.OpA),
    .opb    (bus.OpB),
    .result (dp_result)
  );

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.HiLoEn    = done_q;
  assign bus.HiLoWrite = hilo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: issued ops push the model result and
// the cycle Done is due; a negedge monitor pops and compares on every Done.
module tb_hilo_muldiv_unit;
  import hilo_muldiv_unit_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  logic [63:0] exp_q[$];
  int          due_q[$];
  logic [63:0] last_exp;
  bit          prev_done;

  hilo_muldiv_unit_if #(.WIDTH(W)) bus ();

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural reference, straight from the arithmetic definition of each op.
  function automatic logic [63:0] model(input op_e op, input logic [31:0] a, input logic [31:0] b);
    longint pa;
    longint pb;
    int     sa;
    int     sb;
    int     q;
    int     r;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      OP_MULTU: return {32'd0, a} * {32'd0, b};
      OP_MULT:  return pa * pb;
      OP_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
    endcase
  endfunction

  // Monitor: every Done must match the oldest expectation, on time, for one cycle.
  always @(negedge clk) begin
    if (prev_done) begin
      chk("done_single_cycle", 64'(bus.Done), 64'd0);
      chk("hiloen_follows_done", 64'(bus.HiLoEn), 64'(bus.Done));
      chk("busy_drop_after_done", 64'(bus.Busy), 64'd0);
    end
    prev_done = 1'b0;
    if (bus.Done) begin
      chk("hiloen_with_done", 64'(bus.HiLoEn), 64'd1);
      chk("busy_in_done_cycle", 64'(bus.Busy), 64'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        int d;
        e = exp_q.pop_front();
        d = due_q.pop_front();
        chk("hilo_result", bus.HiLoWrite, e);
        chk("done_latency", 64'(cyc), 64'(d));
      end
      prev_done = 1'b1;
    end
  end

  task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b, input bit expect_done);
    int waited;
    waited = 0;
    @(negedge clk);
    while (bus.Busy && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("issue_wait_idle", 64'(bus.Busy), 64'd0);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.OpA   = a;
    bus.OpB   = b;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    chk("busy_after_accept", 64'(bus.Busy), 64'd1);
    if (expect_done) begin
      last_exp = model(op, a, b);
      exp_q.push_back(last_exp);
      due_q.push_back(cyc + LAT);
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || bus.Busy) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    prev_done = 1'b0;
    last_exp  = '0;
    rst_n     = 1'b0;
    bus.Start = 1'b0;
    bus.Kill  = 1'b0;
    bus.Op    = OP_MULT;
    bus.OpA   = '0;
    bus.OpB   = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus.Busy), 64'd0);
    chk("reset_done", 64'(bus.Done), 64'd0);
    chk("reset_hiloen", 64'(bus.HiLoEn), 64'd0);
    chk("reset_hilo", bus.HiLoWrite, 64'd0);
    rst_n = 1'b1;

    // Directed cases, issued back-to-back.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(OP_MULT,  32'hFFFF_FFFD, 32'd7, 1'b1);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(OP_DIVU,  32'd100, 32'd0, 1'b1);
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(OP_DIV,   32'hFFFF_FF00, 32'd0, 1'b1);
    drain();
    chk("hold_after_idle", bus.HiLoWrite, last_exp);

    // Start while busy with different operands must be dropped.
    issue(OP_MULTU, 32'd1234, 32'd5678, 1'b1);
    repeat (5) @(negedge clk);
    bus.Start = 1'b1;
    bus.Op    = OP_DIVU;
    bus.OpA   = 32'd77;
    bus.OpB   = 32'd3;
    @(negedge clk);
    bus.Start = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    // Kill mid-CALC: no completion, HiLo keeps the previous result.
    issue(OP_DIVU, 32'd55, 32'd5, 1'b0);
    repeat (9) @(negedge clk);
    bus.Kill = 1'b1;
    @(posedge clk);
    #1;
    bus.Kill = 1'b0;
    chk("kill_busy_clear", 64'(bus.Busy), 64'd0);
    chk("kill_hilo_hold", bus.HiLoWrite, last_exp);
    repeat (40) @(negedge clk);
    chk("kill_hilo_hold_late", bus.HiLoWrite, last_exp);
    issue(OP_DIVU, 32'd9, 32'd4, 1'b1);
    drain();

    // Kill together with Start in IDLE: nothing accepted.
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Kill  = 1'b1;
    bus.Op    = OP_MULTU;
    bus.OpA   = 32'd5;
    bus.OpB   = 32'd6;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    bus.Kill  = 1'b0;
    chk("kill_start_ignored", 64'(bus.Busy), 64'd0);
    repeat (40) @(negedge clk);

    // Randomised ops with biased corner operands.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      op_e op;
      op = op_e'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 20);
        2:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      issue(op, a, b, 1'b1);
    end
    drain();

    // Asynchronous reset in the middle of CALC.
    issue(OP_MULTU, 32'd3, 32'd5, 1'b1);
    drain();
    issue(OP_MULTU, $urandom, $urandom, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_busy", 64'(bus.Busy), 64'd0);
    chk("async_reset_done", 64'(bus.Done), 64'd0);
    chk("async_reset_hiloen", 64'(bus.HiLoEn), 64'd0);
    chk("async_reset_hilo", bus.HiLoWrite, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_DIVU, 32'd9, 32'd4, 1'b1);
    drain();
    chk("final_hilo", bus.HiLoWrite, 64'h0000_0001_0000_0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
